dac_spi_frame16: RTL and testbench

Downstream consumer of the 16 per-channel DDS triangle generators. On each `sample_tick` it snapshots all 16 `dac_dds_data` words and serialises them as 24-bit SPI words to an external 16-channel DAC. After the last word it pulses `dac_ldac_n` so that all channels update simultaneously. It provides the only DAC-facing pins of the triangle_16chl subsystem.

---
 rtl/dac_spi_frame16.sv | 204 ++++++++++++++++++++
 tb/tb_dac_spi_frame16.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_frame16.sv
// dac_spi_frame16: snapshots 16 DDS channel words on sample_tick and
// shifts them out as 24-bit SPI words {CMD, channel, data} (mode 0,
// MSB first), then strobes dac_ldac_n so all DAC channels update together.
module dac_spi_frame16 #(
    parameter int         CLK_DIV    = 2,
    parameter int         CS_GAP     = 2,
    parameter int         LDAC_WIDTH = 4,
    parameter logic [3:0] CMD        = 4'b0011
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_tick,
    input  logic [255:0] ch_data,
    output logic         spi_sclk,
    output logic         spi_mosi,
    output logic         spi_cs_n,
    output logic         dac_ldac_n,
    output logic         busy,
    output logic         frame_done,
    output logic [7:0]   overrun_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_LDAC  = 3'd4
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
    // LDAC state spans LDAC_WIDTH low cycles plus one release cycle
    localparam logic [15:0] LDAC_LAST = 16'(LDAC_WIDTH);
    // 48 SCLK toggles per word (24 rising + 24 falling)
    localparam logic [5:0]  EDGE_LAST = 6'd47;

    // Assemble the SPI word for one channel from the frame snapshot
    function automatic logic [23:0] build_word(input logic [3:0]   cmd,
                                               input logic [3:0]   ch,
                                               input logic [255:0] snap);
        build_word = {cmd, ch, snap[{ch, 4'b0000} +: 16]};
    endfunction

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [5:0]    edge_q, edge_d;
    logic [3:0]    ch_q, ch_d;
    logic [255:0]  snap_q, snap_d;
    logic [22:0]   sh_q, sh_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;
    logic          ldac_n_q, ldac_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    ovr_q, ovr_d;
    logic [23:0]   word_s;

    assign word_s = build_word(CMD, ch_q, snap_q);

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        edge_d   = edge_q;
        ch_d     = ch_q;
        snap_d   = snap_q;
        sh_d     = sh_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        ldac_n_d = ldac_n_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q;

        // A tick while a frame is running is dropped and counted
        if (sample_tick && busy_q && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    snap_d  = ch_data;
                    ch_d    = 4'd0;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                sh_d    = word_s[22:0];
                mosi_d  = word_s[23];
                cs_n_d  = 1'b0;
                sclk_d  = 1'b0;
                cnt_d   = 16'd0;
                edge_d  = 6'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d  = 16'd0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 6'd1;
                    // Data advances only on the falling edge
                    if (sclk_q) begin
                        mosi_d = sh_q[22];
                        sh_d   = {sh_q[21:0], 1'b0};
                    end else begin
                        sh_d   = sh_q;
                    end
                    if (edge_q == EDGE_LAST) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (cnt_q == GAP_LAST) begin
                    cnt_d = 16'd0;
                    if (ch_q == 4'd15) begin
                        state_d = ST_LDAC;
                    end else begin
                        ch_d    = ch_q + 4'd1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_LDAC: begin
                if (cnt_q == LDAC_LAST) begin
                    ldac_n_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = 16'd0;
                    state_d  = ST_IDLE;
                end else begin
                    ldac_n_d = 1'b0;
                    cnt_d    = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cs_n_d   = 1'b1;
                sclk_d   = 1'b0;
                ldac_n_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            edge_q   <= 6'd0;
            ch_q     <= 4'd0;
            snap_q   <= 256'd0;
            sh_q     <= 23'd0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            ch_q     <= ch_d;
            snap_q   <= snap_d;
            sh_q     <= sh_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            ldac_n_q <= ldac_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign spi_sclk    = sclk_q;
    assign spi_mosi    = mosi_q;
    assign spi_cs_n    = cs_n_q;
    assign dac_ldac_n  = ldac_n_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_dac_spi_frame16.sv
// Bench for dac_spi_frame16: three instances (default, fast, slow) are
// observed by an SPI slave model that decodes words and measures timing;
// decoded frames are compared with words built from the driven channel data.
module tb_dac_spi_frame16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   tick_v;
    logic [255:0] ch_s;
    logic         mon_clr;

    logic       sclk_s [3];
    logic       mosi_s [3];
    logic       csn_s  [3];
    logic       ldac_s [3];
    logic       busy_s [3];
    logic       fd_s   [3];
    logic [7:0] ovr_s  [3];

    localparam int P_CD [3] = '{2, 1, 5};
    localparam int P_CG [3] = '{2, 1, 2};
    localparam int P_LW [3] = '{4, 4, 10};

    always #5 clk = ~clk;

    dac_spi_frame16 u_dut0 (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick_v[0]), .ch_data(ch_s),
        .spi_sclk(sclk_s[0]), .spi_mosi(mosi_s[0]), .spi_cs_n(csn_s[0]),
        .dac_ldac_n(ldac_s[0]), .busy(busy_s[0]), .frame_done(fd_s[0]),
        .overrun_cnt(ovr_s[0]));

    dac_spi_frame16 #(.CLK_DIV(1), .CS_GAP(1), .LDAC_WIDTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick_v[1]), .ch_data(ch_s),
        .spi_sclk(sclk_s[1]), .spi_mosi(mosi_s[1]), .spi_cs_n(csn_s[1]),
        .dac_ldac_n(ldac_s[1]), .busy(busy_s[1]), .frame_done(fd_s[1]),
        .overrun_cnt(ovr_s[1]));

    dac_spi_frame16 #(.CLK_DIV(5), .CS_GAP(2), .LDAC_WIDTH(10)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .sample_tick(tick_v[2]), .ch_data(ch_s),
        .spi_sclk(sclk_s[2]), .spi_mosi(mosi_s[2]), .spi_cs_n(csn_s[2]),
        .dac_ldac_n(ldac_s[2]), .busy(busy_s[2]), .frame_done(fd_s[2]),
        .overrun_cnt(ovr_s[2]));

    // SPI slave / timing monitor state, written only by the monitor block
    int          n_cap [3];
    logic [23:0] cap_w [3][64];
    int          cap_r [3][64];
    int          rises_cur [3];
    logic [23:0] sh_m [3];
    int          hcnt [3], min_h [3], max_h [3];
    int          gcnt [3], min_g [3], max_g [3];
    int          bcnt [3], busy_len [3];
    int          lcnt [3], ldac_len [3];
    int          fd_cnt [3], prot_err [3];
    logic        p_sclk [3], p_csn [3], p_busy [3], p_ldac [3];

    // Sample all DUT pins away from the active edge and decode the SPI traffic
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (mon_clr) begin
                n_cap[d] = 0; rises_cur[d] = 0; sh_m[d] = 24'd0;
                hcnt[d] = 0; min_h[d] = 1 << 30; max_h[d] = 0;
                gcnt[d] = 0; min_g[d] = 1 << 30; max_g[d] = 0;
                bcnt[d] = 0; busy_len[d] = 0; lcnt[d] = 0; ldac_len[d] = 0;
                fd_cnt[d] = 0; prot_err[d] = 0;
            end else begin
                if (sclk_s[d] && !p_sclk[d]) begin
                    sh_m[d] = {sh_m[d][22:0], mosi_s[d]};
                    rises_cur[d]++;
                    if (csn_s[d]) prot_err[d]++;
                end
                if (sclk_s[d] != p_sclk[d]) begin
                    if (hcnt[d] < min_h[d]) min_h[d] = hcnt[d];
                    if (hcnt[d] > max_h[d]) max_h[d] = hcnt[d];
                    hcnt[d] = 1;
                end else if (!csn_s[d] && p_csn[d]) begin
                    hcnt[d] = 1;
                end else begin
                    hcnt[d]++;
                end
                if (csn_s[d] && !p_csn[d]) begin
                    cap_w[d][n_cap[d] % 64] = sh_m[d];
                    cap_r[d][n_cap[d] % 64] = rises_cur[d];
                    n_cap[d]++;
                    rises_cur[d] = 0;
                    gcnt[d] = 1;
                end else if (csn_s[d]) begin
                    gcnt[d]++;
                end
                if (!csn_s[d] && p_csn[d] && (n_cap[d] % 16 != 0)) begin
                    if (gcnt[d] < min_g[d]) min_g[d] = gcnt[d];
                    if (gcnt[d] > max_g[d]) max_g[d] = gcnt[d];
                end
                if (sclk_s[d] && csn_s[d]) prot_err[d]++;
                if (busy_s[d]) begin
                    bcnt[d]++;
                end else if (p_busy[d]) begin
                    busy_len[d] = bcnt[d];
                    bcnt[d] = 0;
                end
                if (!ldac_s[d]) begin
                    lcnt[d]++;
                    if (!csn_s[d]) prot_err[d]++;
                end else if (!p_ldac[d]) begin
                    ldac_len[d] = lcnt[d];
                    lcnt[d] = 0;
                end
                if (fd_s[d]) begin
                    fd_cnt[d]++;
                    if (busy_s[d]) prot_err[d]++;
                end
            end
            p_sclk[d] = sclk_s[d];
            p_csn[d]  = csn_s[d];
            p_busy[d] = busy_s[d];
            p_ldac[d] = ldac_s[d];
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] chv [16];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_ch();
        for (int k = 0; k < 16; k++) ch_s[k*16 +: 16] = chv[k];
    endtask

    task automatic rand_ch();
        for (int k = 0; k < 16; k++) chv[k] = 16'($urandom);
        drive_ch();
    endtask

    task automatic pulse_tick(input logic [2:0] m);
        @(posedge clk); #1 tick_v = m;
        @(posedge clk); #1 tick_v = 3'b000;
    endtask

    task automatic clr_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int d, input int target, input int budget);
        int n = 0;
        while (fd_cnt[d] < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq($sformatf("frame_done_reached_d%0d", d), 32'(fd_cnt[d] >= target), 32'd1);
    endtask

    // Reference: word k = {command 4'h3, channel k, snapshot value of channel k}
    task automatic check_frame(input int d, input int base, input string tag);
        logic [31:0] e;
        for (int k = 0; k < 16; k++) begin
            e = (32'd3 << 20) | (32'(k) << 16) | 32'(chv[k]);
            chk_eq($sformatf("%s_word%0d", tag, k), 32'(cap_w[d][(base + k) % 64]), e);
            chk_eq($sformatf("%s_rises%0d", tag, k), cap_r[d][(base + k) % 64], 32'd24);
        end
    endtask

    function automatic int busy_expect(input int d);
        return 16 * (1 + 48 * P_CD[d] + P_CG[d]) + P_LW[d] + 1;
    endfunction

    initial begin
        logic [7:0] ovr_save;
        int n;
        rst_n = 1'b0; tick_v = 3'b000; ch_s = 256'd0; mon_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_sclk", sclk_s[0], 1'b0);
        chk_eq("rst_mosi", mosi_s[0], 1'b0);
        chk_eq("rst_cs_n", csn_s[0], 1'b1);
        chk_eq("rst_ldac_n", ldac_s[0], 1'b1);
        chk_eq("rst_busy", busy_s[0], 1'b0);
        chk_eq("rst_frame_done", fd_s[0], 1'b0);
        chk_eq("rst_overrun", ovr_s[0], 8'd0);
        rst_n = 1'b1;
        clr_mon();

        // Single frame on all three parameter sets
        for (int k = 0; k < 16; k++) chv[k] = 16'(k * 16'h0101);
        chv[3] = 16'hA5C3;
        chv[15] = 16'h8000;
        drive_ch();
        pulse_tick(3'b111);
        for (int d = 0; d < 3; d++) wait_done(d, 1, 8000);
        chk_eq("ch3_word", 32'(cap_w[0][3]), 32'h0033A5C3);
        chk_eq("ch15_word", 32'(cap_w[0][15]), 32'h003F8000);
        for (int d = 0; d < 3; d++) begin
            chk_eq($sformatf("words_d%0d", d), n_cap[d], 32'd16);
            check_frame(d, 0, $sformatf("single_d%0d", d));
            chk_eq($sformatf("busy_len_d%0d", d), busy_len[d], busy_expect(d));
            chk_eq($sformatf("ldac_len_d%0d", d), ldac_len[d], P_LW[d]);
            chk_eq($sformatf("half_min_d%0d", d), min_h[d], P_CD[d]);
            chk_eq($sformatf("half_max_d%0d", d), max_h[d], P_CD[d]);
            chk_eq($sformatf("gap_min_d%0d", d), min_g[d], P_CG[d]);
            chk_eq($sformatf("gap_max_d%0d", d), max_g[d], P_CG[d]);
            chk_eq($sformatf("fd_count_d%0d", d), fd_cnt[d], 32'd1);
            chk_eq($sformatf("protocol_d%0d", d), prot_err[d], 32'd0);
        end
        chk_eq("no_overrun", ovr_s[0], 8'd0);

        // Snapshot isolation with random data, inverted after the tick
        for (int it = 0; it < 3; it++) begin
            clr_mon();
            rand_ch();
            pulse_tick(3'b001);
            ch_s = ~ch_s;
            wait_done(0, 1, 3000);
            check_frame(0, 0, $sformatf("snap%0d", it));
            chk_eq("snap_busy_len", busy_len[0], busy_expect(0));
        end

        // Back-to-back: tick in the frame_done cycle
        clr_mon();
        rand_ch();
        pulse_tick(3'b001);
        n = 0;
        while (fd_s[0] !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("b2b_done_seen", fd_s[0], 1'b1);
        check_frame(0, 0, "b2b_a");
        ovr_save = ovr_s[0];
        rand_ch();
        tick_v = 3'b001;
        @(posedge clk); #1 tick_v = 3'b000;
        chk_eq("b2b_busy", busy_s[0], 1'b1);
        chk_eq("b2b_overrun", ovr_s[0], ovr_save);
        wait_done(0, 2, 3000);
        check_frame(0, 16, "b2b_b");
        chk_eq("b2b_busy_len", busy_len[0], busy_expect(0));

        // Overrun: 3 ticks in one frame, then 297 more across the next
        clr_mon();
        rand_ch();
        pulse_tick(3'b001);
        for (int i = 0; i < 3; i++) begin
            repeat (10) @(posedge clk);
            pulse_tick(3'b001);
        end
        chk_eq("overrun_3", ovr_s[0], 8'd3);
        wait_done(0, 1, 3000);
        check_frame(0, 0, "ovr_a");
        chk_eq("overrun_3_after", ovr_s[0], 8'd3);
        clr_mon();
        rand_ch();
        pulse_tick(3'b001);
        for (int i = 0; i < 297; i++) pulse_tick(3'b001);
        chk_eq("overrun_sat", ovr_s[0], 8'd255);
        wait_done(0, 1, 3000);
        check_frame(0, 0, "ovr_b");
        chk_eq("overrun_sat_after", ovr_s[0], 8'd255);

        // Reset in the middle of word 7
        clr_mon();
        rand_ch();
        pulse_tick(3'b001);
        n = 0;
        while (!(n_cap[0] == 7 && rises_cur[0] == 10) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("mid_word7_reached", 32'(n_cap[0] == 7 && rises_cur[0] == 10), 32'd1);
        chk_eq("mid_cs_low", csn_s[0], 1'b0);
        rst_n = 1'b0;
        #1;
        chk_eq("arst_cs_n", csn_s[0], 1'b1);
        chk_eq("arst_sclk", sclk_s[0], 1'b0);
        chk_eq("arst_ldac_n", ldac_s[0], 1'b1);
        chk_eq("arst_busy", busy_s[0], 1'b0);
        chk_eq("arst_mosi", mosi_s[0], 1'b0);
        chk_eq("arst_overrun", ovr_s[0], 8'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        clr_mon();
        rand_ch();
        pulse_tick(3'b001);
        wait_done(0, 1, 3000);
        chk_eq("post_rst_words", n_cap[0], 32'd16);
        check_frame(0, 0, "post_rst");
        chk_eq("post_rst_protocol", prot_err[0], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
